// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of fetch predictions, checked against EX outcomes;
// redirects and flushes on mispredict, drives predictor updates and perf counters.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_hit,
  input  logic [PC_W-1:0] pred_target,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  input  logic [1:0]      res_jumptype,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic [PC_W-1:0] upd_target,
  output logic [1:0]      upd_jumptype,
  output logic [31:0]     cnt_resolved,
  output logic [31:0]     cnt_mispred,
  output logic            err_order
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [PC_W-1:0] nx_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0] count_q, count_d;
  logic redirect_q, redirect_d, upd_valid_q, upd_valid_d, err_q, err_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d, upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic [1:0] upd_jt_q, upd_jt_d;
  logic [31:0] cnt_res_q, cnt_res_d, cnt_mispred_q, cnt_mispred_d;
  logic push, res_act, pop, empty, mispred, upd;
  logic [PC_W-1:0] pred_next, actual_next;
  always_comb begin
    empty = count_q == '0;
    pred_ready = (count_q != FULL) && state_q == RUN;
    push = pred_valid && pred_ready;
    res_act = res_valid && state_q == RUN;
    pop = res_act && !empty;
    pred_next = pred_hit ? pred_target : pred_pc + PC_W'(4);
    actual_next = res_taken ? res_target : res_pc + PC_W'(4);
    mispred = pop && nx_q[head_q] != actual_next;
    upd = pop && res_jumptype != 2'b00;
    state_d = (state_q == RUN && mispred) ? FLUSH : RUN;
    // a mispredict empties the queue and drops any push arriving in the same cycle
    head_d = mispred ? tail_q : head_q + PTR_W'(pop);
    tail_d = mispred ? tail_q : tail_q + PTR_W'(push);
    count_d = mispred ? '0 : count_q + CW'(push) - CW'(pop);
    redirect_d = mispred;
    redirect_pc_d = mispred ? actual_next : redirect_pc_q;
    upd_valid_d = upd;
    upd_pc_d = upd ? res_pc : upd_pc_q;
    upd_target_d = upd ? res_target : upd_target_q;
    upd_jt_d = upd ? res_jumptype : upd_jt_q;
    cnt_res_d = cnt_res_q + {31'd0, pop && !(&cnt_res_q)};
    cnt_mispred_d = cnt_mispred_q + {31'd0, mispred && !(&cnt_mispred_q)};
    err_d = err_q || (res_act && (empty || pc_q[head_q] != res_pc));
  end
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail_q] <= pred_pc;
      nx_q[tail_q] <= pred_next;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      redirect_q <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q <= '0;
      upd_target_q <= '0;
      upd_jt_q <= 2'b00;
      cnt_res_q <= '0;
      cnt_mispred_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      redirect_q <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_jt_q <= upd_jt_d;
      cnt_res_q <= cnt_res_d;
      cnt_mispred_q <= cnt_mispred_d;
      err_q <= err_d;
    end
  end
  assign redirect = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid = upd_valid_q;
  assign upd_pc = upd_pc_q;
  assign upd_target = upd_target_q;
  assign upd_jumptype = upd_jt_q;
  assign cnt_resolved = cnt_res_q;
  assign cnt_mispred = cnt_mispred_q;
  assign err_order = err_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors; redirect/update expectations queued and checked by a monitor.
module tb_branch_resolver;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pred_valid, pred_hit, pred_ready, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_pc, res_target;
  logic [1:0] res_jumptype, upd_jumptype;
  logic redirect, upd_valid, err_order;
  logic [31:0] redirect_pc, upd_pc, upd_target, cnt_resolved, cnt_mispred;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  jt;
  } upd_t;
  logic [31:0] rq[$];
  upd_t uq[$];
  upd_t u;
  int total = 0;
  int passed = 0;

  branch_resolver #(.DEPTH(4), .PC_W(32)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_jumptype(res_jumptype),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_jumptype(upd_jumptype), .cnt_resolved(cnt_resolved),
    .cnt_mispred(cnt_mispred), .err_order(err_order)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  always @(negedge clock) begin
    if (redirect) begin
      if (rq.size() == 0) chk("unexpected_redirect", 32'(redirect), 32'd0);
      else chk("redirect_pc", redirect_pc, rq.pop_front());
    end
    if (upd_valid) begin
      if (uq.size() == 0) chk("unexpected_upd", 32'(upd_valid), 32'd0);
      else begin
        u = uq.pop_front();
        chk("upd_pc", upd_pc, u.pc);
        chk("upd_target", upd_target, u.tgt);
        chk("upd_jumptype", 32'(upd_jumptype), 32'(u.jt));
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
    pred_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    pred_valid = 1'b1;
    pred_pc = pc;
    pred_hit = hit;
    pred_target = tgt;
  endtask

  task automatic res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic [1:0] jt);
    res_valid = 1'b1;
    res_pc = pc;
    res_taken = tk;
    res_target = tgt;
    res_jumptype = jt;
  endtask

  task automatic exp_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] jt);
    uq.push_back({pc, tgt, jt});
  endtask

  task automatic wrap_push(input int i);
    push(32'h80001000 + 32'(16 * i), (i % 2) == 0, 32'h80002000 + 32'(16 * i));
  endtask

  task automatic wrap_res(input int i);
    if ((i % 2) == 0) begin
      res(32'h80001000 + 32'(16 * i), 1'b1, 32'h80002000 + 32'(16 * i), 2'b01);
      exp_upd(32'h80001000 + 32'(16 * i), 32'h80002000 + 32'(16 * i), 2'b01);
    end else res(32'h80001000 + 32'(16 * i), 1'b0, 32'd0, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    pred_valid = 0; pred_pc = 0; pred_hit = 0; pred_target = 0;
    res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0; res_jumptype = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_pred_ready", 32'(pred_ready), 32'd1);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_upd_target", upd_target, 32'd0);
    chk("rst_upd_jt", 32'(upd_jumptype), 32'd0);
    chk("rst_cnt_res", cnt_resolved, 32'd0);
    chk("rst_cnt_mis", cnt_mispred, 32'd0);
    chk("rst_err", 32'(err_order), 32'd0);
    // correct not-taken fall-through
    push(32'h80000000, 1'b0, 32'd0); tick;
    res(32'h80000000, 1'b0, 32'd0, 2'b00); tick;
    chk("t1_cnt_res", cnt_resolved, 32'd1);
    chk("t1_cnt_mis", cnt_mispred, 32'd0);
    chk("t1_upd_valid", 32'(upd_valid), 32'd0);
    // wrong target -> redirect, update, flush cycle
    push(32'h80000010, 1'b1, 32'h80000100); tick;
    res(32'h80000010, 1'b1, 32'h80000200, 2'b01);
    rq.push_back(32'h80000200);
    exp_upd(32'h80000010, 32'h80000200, 2'b01);
    tick;
    chk("t2_redirect", 32'(redirect), 32'd1);
    chk("t2_cnt_mis", cnt_mispred, 32'd1);
    chk("t2_cnt_res", cnt_resolved, 32'd2);
    chk("t2_ready_flush", 32'(pred_ready), 32'd0);
    tick;
    chk("t2_redirect_drop", 32'(redirect), 32'd0);
    chk("t2_ready_back", 32'(pred_ready), 32'd1);
    // fill, then pop+push while full
    for (int i = 0; i < 4; i++) begin
      push(32'h80000a00 + 32'(4 * i), 1'b0, 32'd0); tick;
    end
    chk("t3_full", 32'(pred_ready), 32'd0);
    res(32'h80000a00, 1'b0, 32'd0, 2'b00);
    push(32'h80000b00, 1'b0, 32'd0);
    tick;
    chk("t3_drop_on_full", 32'(pred_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      res(32'h80000a00 + 32'(4 * i), 1'b0, 32'd0, 2'b00); tick;
    end
    chk("t3_cnt_res", cnt_resolved, 32'd6);
    chk("t3_err", 32'(err_order), 32'd0);
    // 10 push/pop pairs crossing the pointer wrap
    wrap_push(0); tick;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) wrap_push(i + 1);
      wrap_res(i);
      tick;
    end
    chk("wrap_cnt_res", cnt_resolved, 32'd16);
    chk("wrap_cnt_mis", cnt_mispred, 32'd1);
    chk("wrap_err", 32'(err_order), 32'd0);
    // correctly predicted call
    push(32'h80000020, 1'b1, 32'h80000400); tick;
    res(32'h80000020, 1'b1, 32'h80000400, 2'b10);
    exp_upd(32'h80000020, 32'h80000400, 2'b10);
    tick;
    chk("call_jt", 32'(upd_jumptype), 32'd2);
    chk("call_cnt_res", cnt_resolved, 32'd17);
    chk("call_cnt_mis", cnt_mispred, 32'd1);
    // mispredict counter saturation, jumptype 00 never updates
    force dut.cnt_mispred_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_mispred_q;
    push(32'h80000030, 1'b0, 32'd0); tick;
    res(32'h80000030, 1'b1, 32'h80000500, 2'b00);
    rq.push_back(32'h80000500);
    tick;
    chk("sat_cnt_mis", cnt_mispred, 32'hFFFFFFFF);
    chk("sat_cnt_res", cnt_resolved, 32'd18);
    chk("sat_no_upd", 32'(upd_valid), 32'd0);
    tick;
    // mispredict with younger entries and a same-cycle push
    push(32'h800000d0, 1'b0, 32'd0); tick;
    push(32'h800000d4, 1'b0, 32'd0); tick;
    push(32'h800000d8, 1'b0, 32'd0); tick;
    res(32'h800000d0, 1'b1, 32'h80000600, 2'b01);
    push(32'h800000dc, 1'b0, 32'd0);
    rq.push_back(32'h80000600);
    exp_upd(32'h800000d0, 32'h80000600, 2'b01);
    tick;
    chk("fl_cnt_res", cnt_resolved, 32'd19);
    chk("fl_ready", 32'(pred_ready), 32'd0);
    tick;
    chk("fl_ready_back", 32'(pred_ready), 32'd1);
    res(32'h800000d4, 1'b0, 32'd0, 2'b01);
    push(32'h80000e00, 1'b0, 32'd0);
    tick;
    chk("empty_err", 32'(err_order), 32'd1);
    chk("empty_cnt_res", cnt_resolved, 32'd19);
    chk("empty_cnt_mis", cnt_mispred, 32'hFFFFFFFF);
    res(32'h80000e00, 1'b0, 32'd0, 2'b00); tick;
    chk("empty_push_kept", cnt_resolved, 32'd20);
    // reset clears sticky error; head PC mismatch
    reset = 1'b1; tick; reset = 1'b0;
    chk("rst2_err", 32'(err_order), 32'd0);
    chk("rst2_cnt_res", cnt_resolved, 32'd0);
    chk("rst2_cnt_mis", cnt_mispred, 32'd0);
    push(32'h80000020, 1'b1, 32'h80000400); tick;
    res(32'h80000024, 1'b1, 32'h80000400, 2'b10);
    exp_upd(32'h80000024, 32'h80000400, 2'b10);
    tick;
    chk("pcm_err", 32'(err_order), 32'd1);
    chk("pcm_cnt_res", cnt_resolved, 32'd1);
    chk("pcm_cnt_mis", cnt_mispred, 32'd0);
    // reset during FLUSH
    push(32'h80000040, 1'b0, 32'd0); tick;
    res(32'h80000040, 1'b1, 32'h80000700, 2'b00);
    rq.push_back(32'h80000700);
    tick;
    chk("rf_ready_flush", 32'(pred_ready), 32'd0);
    reset = 1'b1; tick; reset = 1'b0;
    chk("rf_ready", 32'(pred_ready), 32'd1);
    chk("rf_redirect", 32'(redirect), 32'd0);
    chk("rf_cnt_mis", cnt_mispred, 32'd0);
    push(32'h80000050, 1'b0, 32'd0); tick;
    res(32'h80000050, 1'b0, 32'd0, 2'b00); tick;
    chk("rf_cnt_res", cnt_resolved, 32'd1);
    chk("rf_err", 32'(err_order), 32'd0);
    tick; tick;
    chk("redirect_pending", 32'(rq.size()), 32'd0);
    chk("upd_pending", 32'(uq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution-side companion to the fetch-stage target predictor: records every prediction issued at fetch in a small in-order queue, checks each one against the real outcome when the branch resolves in EX, and on a mismatch issues a one-cycle redirect and flushes all younger in-flight predictions. It also generates the BTB/RAS update request back to the predictor and keeps resolve and mispredict counters for performance reporting.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2)
- PC_W, 32, PC width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pred_valid  in  1  fetch issues a prediction this cycle
- pred_pc  in  PC_W  PC of the fetched instruction
- pred_hit  in  1  predictor hit
- pred_target  in  PC_W  predictor target
- pred_ready  out  1  queue can accept (not full, state RUN)
- res_valid  in  1  EX resolves the oldest in-flight instruction
- res_pc  in  PC_W  PC of the resolving instruction
- res_taken  in  1  actual taken
- res_target  in  PC_W  actual target
- res_jumptype  in  2  00 none, 01 branch/jump, 10 call, 11 ret
- redirect  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  PC_W  correct next PC
- upd_valid  out  1  predictor update strobe
- upd_pc / upd_target  out  PC_W  update entry PC / target
- upd_jumptype  out  2  update type
- cnt_resolved  out  32  resolved instructions
- cnt_mispred  out  32  mispredictions
- err_order  out  1  sticky: resolve with empty queue or PC mismatch at head

## Operation
- Queue entry = {pc, predicted_next}; predicted_next = pred_hit ? pred_target : pred_pc + 4 (mod 2^PC_W).
- Push when pred_valid && pred_ready; pred_valid while !pred_ready is dropped.
- Pop when res_valid in RUN and queue non-empty. actual_next = res_taken ? res_target : res_pc + 4.
- Mispredict = head.predicted_next != actual_next.
- FSM: RUN, FLUSH.
  - RUN → FLUSH on mispredict: register redirect=1, redirect_pc=actual_next; clear queue (head=tail, count=0) at the same edge, discarding any same-cycle push.
  - FLUSH → RUN unconditionally after one cycle; pred_ready=0 and res_valid ignored in FLUSH.
- Update: registered; upd_valid=1 the cycle after a pop with res_jumptype != 00; upd_pc=res_pc, upd_target=res_target, upd_jumptype=res_jumptype. Jumptype 00 pops never update, even on mispredict.
- Counters: cnt_resolved +1 per pop, cnt_mispred +1 per mispredict; both saturate at 0xFFFFFFFF.
- err_order set when res_valid in RUN with empty queue (no pop, no redirect, no count) or head.pc != res_pc (pop proceeds normally). Cleared only by reset.

## Timing
- Reset: queue empty, state RUN, pred_ready=1, redirect=0, redirect_pc=0, upd_valid=0, upd_pc/target=0, upd_jumptype=00, counters=0, err_order=0. Reset mid-flush returns to RUN with empty queue.
- pred_ready is combinational from count and state: (count != DEPTH) && RUN.
- Full with simultaneous push and pop: pop occurs, push refused (pred_ready already 0).
- Empty with simultaneous push and pop: err_order set, push accepted.
- Push + pop in same cycle, neither full nor empty: count unchanged, both pointers advance, wrap mod DEPTH.
- Resolve at edge N → redirect, upd_valid, counters valid in cycle N+1; redirect high exactly one cycle; pred_ready returns in N+2.

## Test plan
- Reset → pred_ready=1, all outputs 0; push pc 0x80000000 hit=0; resolve pc 0x80000000 taken=0 → no redirect, cnt_resolved=1, upd_valid=0.
- Push pc 0x80000010 hit=1 target 0x80000100; resolve taken=1 target 0x80000200 jumptype 01 → next cycle redirect=1, redirect_pc=0x80000200, upd_valid=1, cnt_mispred=1; following cycle pred_ready=0, then 1 with queue empty.
- DEPTH=4: push 4 entries → pred_ready=0; pop+push same cycle → push dropped, count 3; 10 push/pop pairs cross wrap with correct order and no redirect.
- Mispredict with two younger entries queued and a same-cycle push → all discarded; next resolve with empty queue sets err_order=1, counters unchanged.
- Call pc 0x80000020 target 0x80000400 predicted correctly → upd_valid=1, upd_jumptype=10, no redirect; res_pc 0x80000024 against head 0x80000020 → err_order=1.
- Preload cnt_mispred near max via force (0xFFFFFFFF) then mispredict → stays 0xFFFFFFFF; reset asserted during FLUSH → RUN, queue empty next cycle.
